// File: rtl/axis_sync_fifo.sv
// AXI-Stream first-word-fall-through FIFO, single clock, synchronous reset.
// Define AXIS_SYNC_FIFO_PACKET_MODE_EN to present data only once a whole packet is stored.
module axis_sync_fifo #(
    parameter int DATA_WIDTH        = 24,
    parameter int DEPTH             = 1024,
    parameter int PROG_FULL_THRESH  = 768,
    parameter int PROG_EMPTY_THRESH = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     axis_data_count,
    output logic                       prog_full,
    output logic                       prog_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [DATA_WIDTH:0] dout_reg;
    logic [DATA_WIDTH:0] wr_word;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          tready_reg, tvalid_reg, prog_full_reg, prog_empty_reg;
    logic          wr_en, rd_en, valid_next;

    assign wr_word = {s_axis_tlast, s_axis_tdata};
    assign wr_en   = s_axis_tvalid && tready_reg;
    assign rd_en   = tvalid_reg && m_axis_tready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en)
            wr_ptr_next = wr_ptr_reg + AW'(1);
        if (rd_en)
            rd_ptr_next = rd_ptr_reg + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Read port is addressed one cycle ahead so the head word is registered;
    // a write landing on the new head is captured directly into the output register.
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= wr_word;
        if (wr_en && (wr_ptr_reg == rd_ptr_next))
            dout_reg <= wr_word;
        else
            dout_reg <= mem[rd_ptr_next];
    end

`ifdef AXIS_SYNC_FIFO_PACKET_MODE_EN
    logic [CW-1:0] pkt_count_reg, pkt_count_next;
    logic          release_reg, release_next;
    logic          wr_last, rd_last;

    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && dout_reg[DATA_WIDTH];

    // A full FIFO holding no complete packet would deadlock; stream it out
    // until the packet's tlast leaves.
    always_comb begin
        pkt_count_next = pkt_count_reg;
        case ({wr_last, rd_last})
            2'b10:   pkt_count_next = pkt_count_reg + CW'(1);
            2'b01:   pkt_count_next = pkt_count_reg - CW'(1);
            default: pkt_count_next = pkt_count_reg;
        endcase
        release_next = release_reg && !rd_last;
        if ((count_next == FULL_COUNT) && (pkt_count_next == '0))
            release_next = 1'b1;
        valid_next = (count_next != '0) && ((pkt_count_next != '0) || release_next);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count_reg <= '0;
            release_reg   <= 1'b0;
        end else begin
            pkt_count_reg <= pkt_count_next;
            release_reg   <= release_next;
        end
    end
`else
    assign valid_next = (count_next != '0);
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            tready_reg     <= 1'b0;
            tvalid_reg     <= 1'b0;
            prog_full_reg  <= 1'b0;
            prog_empty_reg <= 1'b1;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            tready_reg     <= (count_next != FULL_COUNT);
            tvalid_reg     <= valid_next;
            prog_full_reg  <= (count_next >= CW'(PROG_FULL_THRESH));
            prog_empty_reg <= (count_next <= CW'(PROG_EMPTY_THRESH));
        end
    end

    assign s_axis_tready   = tready_reg;
    assign m_axis_tvalid   = tvalid_reg;
    assign m_axis_tdata    = dout_reg[DATA_WIDTH-1:0];
    assign m_axis_tlast    = dout_reg[DATA_WIDTH];
    assign axis_data_count = count_reg;
    assign prog_full       = prog_full_reg;
    assign prog_empty      = prog_empty_reg;

endmodule
